// File: rtl/mipi_hs_lane_tx.sv
// D-PHY HS lane transmitter: frames a payload stream into one HS burst
// (zeros, sync, payload, trailer) with an optional 0-7 bit delay.
module mipi_hs_lane_tx #(
    parameter int unsigned ZERO_BYTES  = 2,
    parameter int unsigned TRAIL_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hB8
) (
    input  logic       byte_clk,
    input  logic       sys_rst,
    input  logic       tx_req,
    input  logic [2:0] bit_offset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] lane_data,
    output logic       lane_valid,
    output logic       busy,
    output logic       underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_FLUSH
    } state_t;

    localparam logic [3:0] ZERO_LAST  = 4'(ZERO_BYTES - 1);
    localparam logic [3:0] TRAIL_LAST = 4'(TRAIL_BYTES - 1);

    state_t      state_q, state_d;
    state_t      trail_exit;
    logic [2:0]  off_q, off_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_bit_q, last_bit_d;
    logic [7:0]  hist_q, hist_d;
    logic [7:0]  lane_data_q, lane_data_d;
    logic        lane_valid_q, lane_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  raw;
    logic        raw_valid;
    logic [7:0]  trailer;
    logic [15:0] window;

    assign trailer = {8{~last_bit_q}};

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        last_bit_d = last_bit_q;
        hist_d     = hist_q;
        raw        = '0;
        raw_valid  = 1'b0;
        tx_ready   = 1'b0;
        underflow  = 1'b0;
        trail_exit = (off_q != '0) ? S_FLUSH : S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (tx_req) begin
                    state_d = S_ZERO;
                    off_d   = bit_offset;
                    cnt_d   = '0;
                end
            end
            S_ZERO: begin
                raw_valid = 1'b1;
                if (cnt_q == ZERO_LAST) begin
                    state_d = S_SYNC;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SYNC: begin
                raw        = SYNC_BYTE;
                raw_valid  = 1'b1;
                last_bit_d = SYNC_BYTE[7];
                state_d    = S_DATA;
            end
            S_DATA: begin
                tx_ready  = 1'b1;
                raw_valid = 1'b1;
                if (tx_valid) begin
                    raw        = tx_data;
                    last_bit_d = tx_data[7];
                    if (tx_last) begin
                        state_d = S_TRAIL;
                        cnt_d   = '0;
                    end
                end else begin
                    // Starved lane: this cycle already counts as the first trailer byte
                    raw       = trailer;
                    underflow = 1'b1;
                    cnt_d     = 4'd1;
                    state_d   = (TRAIL_BYTES == 1) ? trail_exit : S_TRAIL;
                end
            end
            S_TRAIL: begin
                raw       = trailer;
                raw_valid = 1'b1;
                if (cnt_q == TRAIL_LAST) begin
                    state_d = trail_exit;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FLUSH: begin
                raw       = trailer;
                raw_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // hist stays cleared through IDLE, so every burst starts from zero history
        if (raw_valid) begin
            hist_d = raw;
        end else if (state_q == S_IDLE) begin
            hist_d = '0;
        end
    end

    assign window = {raw, hist_q};

    always_comb begin
        lane_data_d = '0;
        if (raw_valid) begin
            lane_data_d = (off_q == '0) ? raw : 8'(window >> (4'd8 - {1'b0, off_q}));
        end
        lane_valid_d = raw_valid;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge byte_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            off_q        <= '0;
            cnt_q        <= '0;
            last_bit_q   <= 1'b1;
            hist_q       <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            last_bit_q   <= last_bit_d;
            hist_q       <= hist_d;
            lane_data_q  <= lane_data_d;
            lane_valid_q <= lane_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign lane_data  = lane_data_q;
    assign lane_valid = lane_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mipi_hs_lane_tx.sv
// Scoreboard bench for mipi_hs_lane_tx: expected lane bytes are queued by the
// stimulus and consumed by a negedge monitor whenever lane_valid is high.
module tb_mipi_hs_lane_tx;

    logic       byte_clk = 1'b0;
    logic       sys_rst;
    logic       tx_req;
    logic [2:0] bit_offset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic [7:0] lane_data;
    logic       lane_valid;
    logic       busy;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] expq[$];
    logic [7:0] cap[$];
    logic [7:0] pay[8];
    int ready_cnt = 0;
    int uf_cnt    = 0;
    int bursts    = 0;
    int lane_idx  = 0;
    bit lv_prev   = 1'b0;

    mipi_hs_lane_tx #(
        .ZERO_BYTES (2),
        .TRAIL_BYTES(2),
        .SYNC_BYTE  (8'hB8)
    ) dut (
        .byte_clk  (byte_clk),
        .sys_rst   (sys_rst),
        .tx_req    (tx_req),
        .bit_offset(bit_offset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .lane_data (lane_data),
        .lane_valid(lane_valid),
        .busy      (busy),
        .underflow (underflow)
    );

    always #5 byte_clk = ~byte_clk;

    // Scoreboard monitor
    always @(negedge byte_clk) begin
        if (lane_valid) begin
            cap.push_back(lane_data);
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL lane_extra: got %02h expected no byte (idx %0d)", lane_data, lane_idx);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                if (lane_data !== e) begin
                    errors++;
                    $display("FAIL lane_byte[%0d]: got %02h expected %02h", lane_idx, lane_data, e);
                end
            end
            lane_idx++;
        end
        if (tx_ready) ready_cnt++;
        if (underflow) uf_cnt++;
        if (lane_valid && !lv_prev) bursts++;
        lv_prev = lane_valid;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // First byte of the burst is the most significant of the n packed bytes
    task automatic push_bytes(input int n, input logic [63:0] v);
        for (int i = 0; i < n; i++) begin
            logic [63:0] s;
            s = v >> (8 * (n - 1 - i));
            expq.push_back(s[7:0]);
        end
    endtask

    // Bit-level reference: unshifted burst delayed by off zero bits
    task automatic push_model(input int off, input int n);
        logic [7:0] rawq[$];
        bit         bits[$];
        logic [7:0] tr;
        logic [7:0] b;
        int         total;
        rawq.push_back(8'h00);
        rawq.push_back(8'h00);
        rawq.push_back(8'hB8);
        for (int i = 0; i < n; i++) rawq.push_back(pay[i]);
        tr = pay[n-1][7] ? 8'h00 : 8'hFF;
        for (int i = 0; i < 2 + ((off != 0) ? 1 : 0); i++) rawq.push_back(tr);
        for (int i = 0; i < off; i++) bits.push_back(1'b0);
        foreach (rawq[i]) for (int k = 0; k < 8; k++) bits.push_back(rawq[i][k]);
        total = 3 + n + 2 + ((off != 0) ? 1 : 0);
        for (int i = 0; i < total; i++) begin
            for (int k = 0; k < 8; k++) b[k] = bits[8*i + k];
            expq.push_back(b);
        end
    endtask

    task automatic send_burst(input logic [2:0] off, input int n, input int abort_after, input bit hold);
        int idx   = 0;
        int guard = 0;
        bit xfer;
        bit_offset = off;
        tx_req     = 1'b1;
        tx_valid   = (n > 0);
        tx_data    = pay[0];
        tx_last    = (n <= 1);
        @(posedge byte_clk); #1;
        if (!hold) tx_req = 1'b0;
        while (idx < n && guard < 64) begin
            @(negedge byte_clk);
            xfer = tx_ready && tx_valid;
            @(posedge byte_clk); #1;
            guard++;
            if (xfer) begin
                idx++;
                if (idx < n) begin
                    tx_data = pay[idx];
                    tx_last = (idx == n - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
                if (idx == abort_after) begin
                    sys_rst = 1'b1;
                    break;
                end
            end
        end
        if (guard >= 64) chk("payload_timeout", 32'(idx), 32'(n));
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 100) begin
            @(posedge byte_clk); #1;
            guard++;
        end
        chk("busy_timeout", 32'(guard < 100), 1);
        chk("last_byte_at_busy_fall", 32'(lane_valid), 1);
        tx_last = 1'b0;
        @(posedge byte_clk); #1;
        chk("queue_drained", 32'(expq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; tx_req = 1'b0; bit_offset = '0;
        tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
        repeat (3) @(posedge byte_clk);
        #1;
        chk("rst_lane_data", 32'(lane_data), 0);
        chk("rst_lane_valid", 32'(lane_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underflow", 32'(underflow), 0);
        sys_rst = 1'b0;
        @(posedge byte_clk); #1;

        // off=0, two-byte payload
        pay[0] = 8'h11; pay[1] = 8'h22;
        ready_cnt = 0; uf_cnt = 0;
        push_bytes(7, 64'h00_00_B8_11_22_FF_FF);
        send_burst(3'd0, 2, -1, 1'b0);
        wait_idle();
        chk("ready_cycles_off0", 32'(ready_cnt), 2);
        chk("no_underflow_off0", 32'(uf_cnt), 0);
        chk("busy_low_after", 32'(busy), 0);

        // off=2 with flush byte
        pay[0] = 8'hA5;
        push_bytes(7, 64'h00_00_E0_96_02_00_00);
        send_burst(3'd2, 1, -1, 1'b0);
        wait_idle();

        // Starved payload right after sync; tx_last without tx_valid is ignored
        ready_cnt = 0; uf_cnt = 0;
        push_bytes(5, 64'h00_00_B8_00_00);
        send_burst(3'd0, 0, -1, 1'b0);
        wait_idle();
        chk("underflow_pulses", 32'(uf_cnt), 1);
        chk("ready_cycles_underflow", 32'(ready_cnt), 1);

        // tx_req held high through a burst: only re-accepted once busy falls
        pay[0] = 8'h11; pay[1] = 8'h22;
        bursts = 0; uf_cnt = 0;
        push_bytes(7, 64'h00_00_B8_11_22_FF_FF);
        send_burst(3'd0, 2, -1, 1'b1);
        bit_offset = 3'd5;
        wait_idle();
        push_bytes(6, 64'h00_00_00_17_00_00);
        tx_req = 1'b0;
        chk("rearm_busy", 32'(busy), 1);
        wait_idle();
        chk("separate_bursts", 32'(bursts), 2);
        chk("rearm_underflow", 32'(uf_cnt), 1);

        // Reset mid-payload
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        push_bytes(4, 64'h00_00_B8_11);
        send_burst(3'd0, 4, 1, 1'b0);
        @(posedge byte_clk); #1;
        chk("abort_lane_valid", 32'(lane_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tx_ready", 32'(tx_ready), 0);
        chk("abort_lane_data", 32'(lane_data), 0);
        sys_rst = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
        chk("abort_queue", 32'(expq.size()), 0);
        pay[0] = 8'h14;
        push_bytes(6, 64'h00_00_B8_14_FF_FF);
        send_burst(3'd0, 1, -1, 1'b0);
        wait_idle();

        // Every bit offset, recovered with a bit-level sync search
        for (int o = 0; o < 8; o++) begin
            int   found;
            bit   bits[$];
            logic [7:0] b;
            for (int i = 0; i < 6; i++) pay[i] = 8'(8'h14 + i);
            cap.delete();
            push_model(o, 6);
            send_burst(3'(o), 6, -1, 1'b0);
            wait_idle();
            foreach (cap[i]) for (int k = 0; k < 8; k++) bits.push_back(cap[i][k]);
            found = -1;
            for (int i = 0; i + 8 <= bits.size() && found < 0; i++) begin
                for (int k = 0; k < 8; k++) b[k] = bits[i + k];
                if (b == 8'hB8) found = i;
            end
            chk("sync_found", 32'(found >= 0), 1);
            if (found >= 0) begin
                for (int j = 0; j < 6; j++) begin
                    b = '0;
                    for (int k = 0; k < 8; k++)
                        if (found + 8 + 8*j + k < bits.size()) b[k] = bits[found + 8 + 8*j + k];
                    chk($sformatf("loopback_off%0d_byte%0d", o, j), 32'(b), 32'(8'h14 + j));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
